// File: rtl/tracker.sv
`timescale 1ns/1ps
// tracker: streaming colour-blob tracker for the camera/VGA path.
// Consumes one raster-ordered frame of RGB pixels, classifies each pixel
// against a red-target threshold and reports the target position at end of
// frame, with a held valid flag.
//
// Optional build macro: TRACKER_BBOX_EN
//   undefined : integer centroid via two 28-cycle restoring dividers
//   defined   : bounding-box midpoint (dividers removed, same 28-cycle wait)
//
// Ports:
//   i_clk       system clock (pixel domain)
//   i_rst_n     asynchronous active-low reset
//   i_RGB       pixel colour, R=[23:16] G=[15:8] B=[7:0]
//   i_pixelVAL  pixel strobe, one pixel per high cycle
//   o_pointH    target column (3FF when no target pixel in the frame)
//   o_pointV    target row    (3FF when no target pixel in the frame)
//   o_valid     result valid, held until the next accepted pixel
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACCUM | accepting pixels, accumulating target statistics
// ST_DIV   | 28-cycle result computation, incoming pixels dropped
// ST_DONE  | result held, o_valid=1; next pixel starts a new frame at (0,0)
module tracker #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int R_MIN  = 200,
  parameter int GB_MAX = 80
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_RGB,
  input  logic        i_pixelVAL,
  output logic [9:0]  o_pointH,
  output logic [9:0]  o_pointV,
  output logic        o_valid
);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DIV   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [9:0] H_LAST   = 10'(H_RES - 1);
  localparam logic [9:0] V_LAST   = 10'(V_RES - 1);
  localparam logic [4:0] DIV_LOAD = 5'd28;

  logic [1:0]  r_state;
  logic [9:0]  r_h, r_v;
  logic [18:0] r_cnt;
  logic [4:0]  r_div_cnt;
  logic [9:0]  r_point_h, r_point_v;

  logic        w_target, w_accept, w_restart, w_last;
  logic [9:0]  w_ph, w_pv, w_h_nxt, w_v_nxt;
  logic [18:0] w_cnt_base, w_cnt_nxt;
  logic [9:0]  w_res_h, w_res_v;

  assign w_target = (i_RGB[23:16] >= 8'(R_MIN)) &&
                    (i_RGB[15:8]  <= 8'(GB_MAX)) &&
                    (i_RGB[7:0]   <= 8'(GB_MAX));

  assign w_accept  = i_pixelVAL && (r_state != ST_DIV);
  // A pixel taken in DONE begins a fresh frame: it is treated as (0,0)
  // against cleared accumulators in the same edge.
  assign w_restart = (r_state == ST_DONE);

  assign w_ph    = w_restart ? 10'd0 : r_h;
  assign w_pv    = w_restart ? 10'd0 : r_v;
  assign w_last  = (w_ph == H_LAST) && (w_pv == V_LAST);
  assign w_h_nxt = (w_ph == H_LAST) ? 10'd0 : w_ph + 10'd1;
  assign w_v_nxt = (w_ph != H_LAST) ? w_pv :
                   (w_pv == V_LAST) ? 10'd0 : w_pv + 10'd1;

  assign w_cnt_base = w_restart ? 19'd0 : r_cnt;
  assign w_cnt_nxt  = w_cnt_base + (w_target ? 19'd1 : 19'd0);

`ifdef TRACKER_BBOX_EN
  logic [9:0] r_min_h, r_max_h, r_min_v, r_max_v;
  logic [9:0] w_min_h_b, w_max_h_b, w_min_v_b, w_max_v_b;
  logic [9:0] w_min_h_nxt, w_max_h_nxt, w_min_v_nxt, w_max_v_nxt;

  assign w_min_h_b = w_restart ? 10'h3FF : r_min_h;
  assign w_max_h_b = w_restart ? 10'h000 : r_max_h;
  assign w_min_v_b = w_restart ? 10'h3FF : r_min_v;
  assign w_max_v_b = w_restart ? 10'h000 : r_max_v;

  assign w_min_h_nxt = (w_target && (w_ph < w_min_h_b)) ? w_ph : w_min_h_b;
  assign w_max_h_nxt = (w_target && (w_ph > w_max_h_b)) ? w_ph : w_max_h_b;
  assign w_min_v_nxt = (w_target && (w_pv < w_min_v_b)) ? w_pv : w_min_v_b;
  assign w_max_v_nxt = (w_target && (w_pv > w_max_v_b)) ? w_pv : w_max_v_b;

  assign w_res_h = 10'(({1'b0, r_min_h} + {1'b0, r_max_h}) >> 1);
  assign w_res_v = 10'(({1'b0, r_min_v} + {1'b0, r_max_v}) >> 1);
`else
  logic [27:0] r_sum_h, r_sum_v;
  logic [27:0] w_sum_h_nxt, w_sum_v_nxt;
  // Divider: r_quo starts as the dividend and shifts left, quotient bits
  // entering at the bottom; r_rem stays below the divisor so 19 bits suffice.
  logic [18:0] r_rem_h, r_rem_v;
  logic [27:0] r_quo_h, r_quo_v;
  logic [46:0] w_step_h, w_step_v;

  function automatic logic [46:0] div_step(input logic [18:0] rem,
                                           input logic [27:0] quo,
                                           input logic [18:0] den);
    logic [19:0] sh;
    logic [18:0] rem_n;
    logic        q_bit;
    sh = {rem, quo[27]};
    if (sh >= {1'b0, den}) begin
      rem_n = sh[18:0] - den;
      q_bit = 1'b1;
    end else begin
      rem_n = sh[18:0];
      q_bit = 1'b0;
    end
    return {rem_n, quo[26:0], q_bit};
  endfunction

  assign w_sum_h_nxt = (w_restart ? 28'd0 : r_sum_h) + (w_target ? 28'(w_ph) : 28'd0);
  assign w_sum_v_nxt = (w_restart ? 28'd0 : r_sum_v) + (w_target ? 28'(w_pv) : 28'd0);

  assign w_step_h = div_step(r_rem_h, r_quo_h, r_cnt);
  assign w_step_v = div_step(r_rem_v, r_quo_v, r_cnt);

  assign w_res_h = r_quo_h[9:0];
  assign w_res_v = r_quo_v[9:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_ACCUM;
      r_h       <= '0;
      r_v       <= '0;
      r_cnt     <= '0;
      r_div_cnt <= '0;
      r_point_h <= '0;
      r_point_v <= '0;
`ifdef TRACKER_BBOX_EN
      r_min_h   <= 10'h3FF;
      r_max_h   <= 10'h000;
      r_min_v   <= 10'h3FF;
      r_max_v   <= 10'h000;
`else
      r_sum_h   <= '0;
      r_sum_v   <= '0;
      r_rem_h   <= '0;
      r_rem_v   <= '0;
      r_quo_h   <= '0;
      r_quo_v   <= '0;
`endif
    end else if (w_accept) begin
      r_h   <= w_h_nxt;
      r_v   <= w_v_nxt;
      r_cnt <= w_cnt_nxt;
`ifdef TRACKER_BBOX_EN
      r_min_h <= w_min_h_nxt;
      r_max_h <= w_max_h_nxt;
      r_min_v <= w_min_v_nxt;
      r_max_v <= w_max_v_nxt;
`else
      r_sum_h <= w_sum_h_nxt;
      r_sum_v <= w_sum_v_nxt;
`endif
      if (w_last) begin
        r_state   <= ST_DIV;
        r_div_cnt <= DIV_LOAD;
`ifndef TRACKER_BBOX_EN
        // Dividers load straight from the final sums so no cycle is lost.
        r_rem_h <= '0;
        r_rem_v <= '0;
        r_quo_h <= w_sum_h_nxt;
        r_quo_v <= w_sum_v_nxt;
`endif
      end else begin
        r_state <= ST_ACCUM;
      end
    end else if (r_state == ST_DIV) begin
      // 28 iteration edges, then one load edge.
      if (r_div_cnt == 5'd0) begin
        r_state   <= ST_DONE;
        r_point_h <= (r_cnt == 19'd0) ? 10'h3FF : w_res_h;
        r_point_v <= (r_cnt == 19'd0) ? 10'h3FF : w_res_v;
      end else begin
        r_div_cnt <= r_div_cnt - 5'd1;
`ifndef TRACKER_BBOX_EN
        r_rem_h <= w_step_h[46:28];
        r_quo_h <= w_step_h[27:0];
        r_rem_v <= w_step_v[46:28];
        r_quo_v <= w_step_v[27:0];
`endif
      end
    end
  end

  assign o_pointH = r_point_h;
  assign o_pointV = r_point_v;
  assign o_valid  = (r_state == ST_DONE);

endmodule

// File: tb/tb_tracker.sv
`timescale 1ns/1ps
module tb_tracker;
  localparam int H = 104;
  localparam int V = 52;
  localparam int N = H * V;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [23:0] i_RGB;
  logic        i_pixelVAL;
  logic [9:0]  o_pointH, o_pointV;
  logic        o_valid;

  int checks = 0;
  int errors = 0;

  logic [23:0] img [N];

  tracker #(.H_RES(H), .V_RES(V), .R_MIN(200), .GB_MAX(80)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_RGB(i_RGB), .i_pixelVAL(i_pixelVAL),
    .o_pointH(o_pointH), .o_pointV(o_pointV), .o_valid(o_valid)
  );

  always #20 i_clk = ~i_clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < N; i++) img[i] = 24'h0;
  endtask

  task automatic set_px(input int h, input int v, input logic [23:0] c);
    img[v * H + h] = c;
  endtask

  task automatic rand_img();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(99) < 3)
        img[i] = {8'($urandom_range(255, 195)), 8'($urandom_range(85, 0)), 8'($urandom_range(85, 0))};
      else
        img[i] = {8'($urandom_range(199, 0)), 8'($urandom), 8'($urandom)};
    end
  endtask

  // Reference: scan the whole image, pick target pixels by the colour rule,
  // then centroid (or bounding-box midpoint) with plain integer arithmetic.
  task automatic model(output logic [9:0] eh, output logic [9:0] ev);
    int sh, sv, cnt, mnh, mxh, mnv, mxv, r, g, b, h, v;
    sh = 0; sv = 0; cnt = 0; mnh = 1023; mxh = 0; mnv = 1023; mxv = 0;
    for (int i = 0; i < N; i++) begin
      r = int'(img[i][23:16]); g = int'(img[i][15:8]); b = int'(img[i][7:0]);
      if (r >= 200 && g <= 80 && b <= 80) begin
        h = i % H; v = i / H;
        sh += h; sv += v; cnt++;
        if (h < mnh) mnh = h;
        if (h > mxh) mxh = h;
        if (v < mnv) mnv = v;
        if (v > mxv) mxv = v;
      end
    end
    if (cnt == 0) begin
      eh = 10'h3FF; ev = 10'h3FF;
    end else begin
`ifdef TRACKER_BBOX_EN
      eh = 10'((mnh + mxh) / 2); ev = 10'((mnv + mxv) / 2);
`else
      eh = 10'(sh / cnt); ev = 10'(sv / cnt);
`endif
    end
  endtask

  task automatic send_range(input int first, input int last, input int gap_pct);
    for (int i = first; i <= last; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        i_pixelVAL = 1'b0; @(posedge i_clk); #1;
      end
      i_RGB = img[i]; i_pixelVAL = 1'b1;
      @(posedge i_clk); #1;
    end
    i_pixelVAL = 1'b0; i_RGB = 24'h0;
  endtask

  // Called just after the edge accepting the last pixel; counts edges until
  // o_valid, optionally pulsing red pixels during the division window.
  task automatic finish_frame(input string tag, input bit pulse);
    logic [9:0] eh, ev;
    int n;
    model(eh, ev);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (pulse && k < 20) begin
        i_pixelVAL = 1'($urandom_range(1));
        i_RGB = 24'hFF0000;
      end
      @(posedge i_clk); #1;
      i_pixelVAL = 1'b0; i_RGB = 24'h0;
      n++;
      if (o_valid) break;
    end
    chk({tag, "_latency"}, n, 29);
    chk({tag, "_valid"}, o_valid, 1);
    chk({tag, "_H"}, o_pointH, eh);
    chk({tag, "_V"}, o_pointV, ev);
  endtask

  initial begin
    int low;
    i_rst_n = 1'b0; i_pixelVAL = 1'b0; i_RGB = 24'h0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_H", o_pointH, 0);
    chk("rst_V", o_pointV, 0);
    chk("rst_valid", o_valid, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Random frame with gaps
    rand_img();
    send_range(0, N - 1, 10);
    finish_frame("rand1", 1'b0);

    // Abort mid-frame with reset
    rand_img();
    send_range(0, 999, 0);
    chk("mid_valid", o_valid, 0);
    i_rst_n = 1'b0;
    #3;
    chk("midrst_H", o_pointH, 0);
    chk("midrst_V", o_pointV, 0);
    chk("midrst_valid", o_valid, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Single target at (5,7)
    clear_img();
    set_px(5, 7, 24'hFF0000);
    send_range(0, N - 1, 5);
    finish_frame("t57", 1'b0);
    chk("t57_const_H", o_pointH, 5);
    chk("t57_const_V", o_pointV, 7);

    // All-black frame -> sentinel
    clear_img();
    send_range(0, N - 1, 0);
    finish_frame("black", 1'b0);
    chk("black_const_H", o_pointH, 1023);
    chk("black_const_V", o_pointV, 1023);

    // Single pixel at (100,50), then hold for 100 idle cycles
    clear_img();
    set_px(100, 50, 24'hFF0000);
    send_range(0, N - 1, 5);
    finish_frame("p100", 1'b0);
    low = 0;
    repeat (100) begin
      @(posedge i_clk); #1;
      if (!o_valid) low++;
    end
    chk("hold_low_cycles", low, 0);
    chk("hold_H", o_pointH, 100);
    chk("hold_V", o_pointV, 50);

    // Block 10..13 x 20..21; first pixel taken in DONE drops o_valid
    clear_img();
    for (int v = 20; v <= 21; v++)
      for (int h = 10; h <= 13; h++) set_px(h, v, 24'hFF0000);
    send_range(0, 0, 0);
    chk("done_drop_valid", o_valid, 0);
    send_range(1, N - 1, 5);
    finish_frame("block", 1'b0);
    chk("block_const_H", o_pointH, 11);
    chk("block_const_V", o_pointV, 20);

    // Threshold edges
    clear_img();
    set_px(0, 0, {8'd200, 8'd80, 8'd80});
    set_px(1, 0, {8'd199, 8'd0, 8'd0});
    set_px(2, 0, {8'd255, 8'd81, 8'd0});
    set_px(50, 30, {8'd255, 8'd0, 8'd81});
    send_range(0, N - 1, 0);
    finish_frame("thresh", 1'b0);
    chk("thresh_const_H", o_pointH, 0);
    chk("thresh_const_V", o_pointV, 0);

    // Random frame with pixels pulsed during the division window
    rand_img();
    send_range(0, N - 1, 10);
    finish_frame("divpulse", 1'b1);

    // Random frame right after, starting from DONE
    rand_img();
    send_range(0, N - 1, 0);
    finish_frame("rand2", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
